// File: rtl/core_seq_pkg.sv
// Shared types and field positions for the core run-control sequencer.
// Imported by the sequencer top; the bench uses literal values instead.
package core_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAULT   = 3'd4,
    ST_TIMEOUT = 3'd5
  } seq_state_t;

  // CSTAT bit positions
  localparam int unsigned CS_HALT     = 0;
  localparam int unsigned CS_FAULT    = 1;
  localparam int unsigned CS_EXIT_LSB = 8;

  // SEQ_STAT field positions
  localparam int unsigned SS_STATE_LSB = 0;
  localparam int unsigned SS_STATE_W   = 3;
  localparam int unsigned SS_BUSY      = 3;
  localparam int unsigned SS_DONE      = 4;
  localparam int unsigned SS_FAULT     = 5;
  localparam int unsigned SS_TIMEOUT   = 6;
  localparam int unsigned SS_EXIT_LSB  = 8;
  localparam int unsigned EXIT_W       = 8;

  function automatic int unsigned rst_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic logic is_busy(input seq_state_t s);
    return (s == ST_RESET) || (s == ST_RUN);
  endfunction

  function automatic logic can_start(input seq_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAULT) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/core_seq_if.sv
// Controller/core-facing signal bundle of the sequencer.
// The master side drives requests and core status; the slave side is the sequencer.
interface core_seq_if;
  logic        CRST;
  logic        CEXEC;
  logic [31:0] CMEM_ADDR;
  logic [15:0] CSTAT;
  logic        CORE_RST;
  logic        CORE_EN;
  logic [31:0] CORE_PC;
  logic [15:0] SEQ_STAT;
  logic [31:0] CYCLE_CNT;

  modport master (
    output CRST, CEXEC, CMEM_ADDR, CSTAT,
    input  CORE_RST, CORE_EN, CORE_PC, SEQ_STAT, CYCLE_CNT
  );

  modport slave (
    input  CRST, CEXEC, CMEM_ADDR, CSTAT,
    output CORE_RST, CORE_EN, CORE_PC, SEQ_STAT, CYCLE_CNT
  );
endinterface

// File: rtl/core_sequencer_cycle_counter.sv
// 32-bit saturating run-cycle counter with synchronous clear and a flag
// that is high when the next increment would reach LIMIT.
module seq_cycle_counter #(
  parameter logic [31:0] LIMIT = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [31:0] o_cnt,
  output logic        o_next_at_limit
);

  logic [31:0] r_cnt;
  logic        w_sat;

  assign w_sat = (r_cnt == '1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_sat) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_cnt = r_cnt;
  // 33-bit compare so a saturated count never aliases onto LIMIT
  assign o_next_at_limit = (({1'b0, r_cnt} + 33'd1) == {1'b0, LIMIT});

endmodule

// File: rtl/core_sequencer.sv
// Run-control sequencer: turns a CEXEC rising edge into a timed core reset/run
// sequence and reports halt/fault/timeout plus a run-cycle count in SEQ_STAT.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 4,
  parameter logic [31:0] MAX_CYCLES = 32'd1000000
) (
  input  logic       CCLK,
  input  logic       S_AXI_ARSTN,
  core_seq_if.slave  bus
);

  localparam int unsigned      RCW      = rst_cnt_width(RST_CYCLES);
  localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYCLES - 1);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic             r_cexec_q;
  logic [RCW-1:0]   r_rst_cnt;
  logic             r_core_rst;
  logic             r_core_en;
  logic [31:0]      r_core_pc;
  logic             r_done;
  logic             r_fault;
  logic             r_timeout;
  logic [EXIT_W-1:0] r_exit;

  logic             w_abort;
  logic             w_start;
  logic             w_status_ok;
  logic             w_exit_fault;
  logic             w_exit_done;
  logic             w_exit_tmo;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_cnt_hit;
  logic [31:0]      w_cycle_cnt;
  logic [15:0]      w_seq_stat;

  seq_cycle_counter #(
    .LIMIT (MAX_CYCLES)
  ) u_cycle_cnt (
    .i_clk           (CCLK),
    .i_rst_n         (S_AXI_ARSTN),
    .i_clr           (w_cnt_clr),
    .i_en            (w_cnt_en),
    .o_cnt           (w_cycle_cnt),
    .o_next_at_limit (w_cnt_hit)
  );

  always_comb begin
    w_abort      = bus.CRST;
    w_start      = bus.CEXEC & ~r_cexec_q & ~bus.CRST & can_start(r_state);
    // first RUN cycle still sees the previous run's status; mask it
    w_status_ok  = (r_state == ST_RUN) && (w_cycle_cnt != '0);
    w_exit_fault = w_status_ok && bus.CSTAT[CS_FAULT];
    w_exit_done  = w_status_ok && bus.CSTAT[CS_HALT] && !bus.CSTAT[CS_FAULT];
    w_exit_tmo   = (r_state == ST_RUN) && (MAX_CYCLES != '0) && w_cnt_hit
                   && !w_exit_fault && !w_exit_done;

    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAULT, ST_TIMEOUT: begin
        if (w_start) w_state_nxt = ST_RESET;
      end
      ST_RESET: begin
        if (r_rst_cnt == RST_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_exit_fault)     w_state_nxt = ST_FAULT;
        else if (w_exit_done) w_state_nxt = ST_DONE;
        else if (w_exit_tmo)  w_state_nxt = ST_TIMEOUT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_IDLE;

    w_cnt_clr = w_abort | w_start;
    w_cnt_en  = (r_state == ST_RUN);
  end

  always_ff @(posedge CCLK or negedge S_AXI_ARSTN) begin
    if (!S_AXI_ARSTN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CCLK or negedge S_AXI_ARSTN) begin
    if (!S_AXI_ARSTN) begin
      r_cexec_q  <= 1'b0;
      r_rst_cnt  <= '0;
      r_core_rst <= 1'b1;
      r_core_en  <= 1'b0;
      r_core_pc  <= '0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
      r_timeout  <= 1'b0;
      r_exit     <= '0;
    end else begin
      r_cexec_q  <= bus.CEXEC;
      // outputs follow the next state so they change on the same edge as the state
      r_core_rst <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RESET);
      r_core_en  <= (w_state_nxt == ST_RUN);
      r_rst_cnt  <= ((r_state == ST_RESET) && (w_state_nxt == ST_RESET))
                    ? r_rst_cnt + 1'b1 : '0;

      if (w_abort) begin
        r_done    <= 1'b0;
        r_fault   <= 1'b0;
        r_timeout <= 1'b0;
        r_exit    <= '0;
      end else if (w_start) begin
        r_core_pc <= bus.CMEM_ADDR;
        r_done    <= 1'b0;
        r_fault   <= 1'b0;
        r_timeout <= 1'b0;
        r_exit    <= '0;
      end else if (w_exit_fault) begin
        r_fault   <= 1'b1;
        r_exit    <= bus.CSTAT[CS_EXIT_LSB +: EXIT_W];
      end else if (w_exit_done) begin
        r_done    <= 1'b1;
        r_exit    <= bus.CSTAT[CS_EXIT_LSB +: EXIT_W];
      end else if (w_exit_tmo) begin
        r_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    w_seq_stat = '0;
    w_seq_stat[SS_STATE_LSB +: SS_STATE_W] = r_state;
    w_seq_stat[SS_BUSY]                    = is_busy(r_state);
    w_seq_stat[SS_DONE]                    = r_done;
    w_seq_stat[SS_FAULT]                   = r_fault;
    w_seq_stat[SS_TIMEOUT]                 = r_timeout;
    w_seq_stat[SS_EXIT_LSB +: EXIT_W]      = r_exit;
  end

  assign bus.CORE_RST  = r_core_rst;
  assign bus.CORE_EN   = r_core_en;
  assign bus.CORE_PC   = r_core_pc;
  assign bus.SEQ_STAT  = w_seq_stat;
  assign bus.CYCLE_CNT = w_cycle_cnt;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: each run pushes its expected terminal
// status/count/PC, and a monitor pops and compares on entry to DONE/FAULT/TIMEOUT.
module tb_core_sequencer;

  localparam int unsigned RSTC = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_seq_if bus();

  core_sequencer #(
    .RST_CYCLES (RSTC),
    .MAX_CYCLES (32'd50)
  ) dut (
    .CCLK        (clk),
    .S_AXI_ARSTN (rst_n),
    .bus         (bus)
  );

  typedef struct {
    logic [15:0] stat;
    logic [31:0] cnt;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   mon_term;
  bit   prev_term = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    mon_term = rst_n && (bus.SEQ_STAT[2:0] inside {3'd3, 3'd4, 3'd5});
    if (mon_term && !prev_term) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_exit", {16'h0, bus.SEQ_STAT}, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_stat", {16'h0, bus.SEQ_STAT}, {16'h0, mon_e.stat});
        chk("sb_cnt", bus.CYCLE_CNT, mon_e.cnt);
        chk("sb_pc", bus.CORE_PC, mon_e.pc);
        chk("sb_rst_en", {30'h0, bus.CORE_RST, bus.CORE_EN}, 32'h0);
      end
      n_pop++;
    end
    prev_term = mon_term;
  end

  task automatic do_run(input logic [31:0] addr, input int unsigned exit_cyc,
                        input logic [15:0] cstat, input logic [15:0] exp_stat,
                        input logic [31:0] exp_cnt, input bit stale, input bit retrig);
    int pops0;
    bus.CEXEC = 1'b0;
    bus.CSTAT = stale ? 16'h0001 : 16'h0000;
    tick();
    bus.CMEM_ADDR = addr;
    bus.CEXEC     = 1'b1;
    tick();
    chk("start_stat", {16'h0, bus.SEQ_STAT}, 32'h0009);
    chk("start_pc", bus.CORE_PC, addr);
    chk("start_cnt", bus.CYCLE_CNT, 32'h0);
    sb_q.push_back('{exp_stat, exp_cnt, addr});
    for (int i = 1; i < int'(RSTC); i++) begin
      tick();
      chk("rst_hold", {30'h0, bus.CORE_RST, bus.CORE_EN}, 32'h2);
    end
    tick();
    chk("run_entry", {30'h0, bus.CORE_RST, bus.CORE_EN}, 32'h1);
    chk("run_stat", {16'h0, bus.SEQ_STAT}, 32'h000A);
    pops0 = n_pop;
    for (int k = 1; k <= 200 && n_pop == pops0; k++) begin
      bus.CSTAT = (k == int'(exit_cyc)) ? cstat : (stale ? 16'h0001 : 16'h0000);
      if (retrig && k == 3) bus.CEXEC = 1'b0;
      if (retrig && k == 4) begin
        bus.CEXEC     = 1'b1;
        bus.CMEM_ADDR = 32'hDEAD_0000;
      end
      tick();
      if (stale && k == 1)  chk("stale_ignored", {16'h0, bus.SEQ_STAT}, 32'h000A);
      if (retrig && k == 4) chk("busy_retrig", {16'h0, bus.SEQ_STAT}, 32'h000A);
    end
    chk("run_exit_seen", n_pop - pops0, 32'd1);
    bus.CSTAT = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.CRST      = 1'b0;
    bus.CEXEC     = 1'b0;
    bus.CMEM_ADDR = '0;
    bus.CSTAT     = '0;
    #8;
    chk("rst_core_rst", {31'h0, bus.CORE_RST}, 32'h1);
    chk("rst_core_en", {31'h0, bus.CORE_EN}, 32'h0);
    chk("rst_pc", bus.CORE_PC, 32'h0);
    chk("rst_stat", {16'h0, bus.SEQ_STAT}, 32'h0);
    chk("rst_cnt", bus.CYCLE_CNT, 32'h0);
    #4 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_stat", {16'h0, bus.SEQ_STAT}, 32'h0);
      chk("idle_rst_en", {30'h0, bus.CORE_RST, bus.CORE_EN}, 32'h2);
      chk("idle_cnt", bus.CYCLE_CNT, 32'h0);
    end

    do_run(32'h0000_0100, 20, 16'h2A01, 16'h2A13, 32'd20, 1'b0, 1'b0);
    do_run(32'h0000_0200,  5, 16'h0503, 16'h0524, 32'd5,  1'b0, 1'b0);
    do_run(32'h0000_0300,  0, 16'h0000, 16'h0045, 32'd50, 1'b0, 1'b0);
    do_run(32'h0000_0350, 50, 16'h0001, 16'h0013, 32'd50, 1'b0, 1'b0);

    // abort out of a terminal state clears flags and count
    bus.CRST = 1'b1;
    tick();
    chk("abort_done_stat", {16'h0, bus.SEQ_STAT}, 32'h0);
    chk("abort_done_cnt", bus.CYCLE_CNT, 32'h0);
    chk("abort_done_rst_en", {30'h0, bus.CORE_RST, bus.CORE_EN}, 32'h2);
    bus.CRST = 1'b0;

    // abort mid-run with CEXEC held high
    bus.CEXEC = 1'b0;
    tick();
    bus.CMEM_ADDR = 32'h0000_0400;
    bus.CEXEC     = 1'b1;
    tick();
    repeat (RSTC + 5) tick();
    chk("abort_pre_stat", {16'h0, bus.SEQ_STAT}, 32'h000A);
    chk("abort_pre_cnt", bus.CYCLE_CNT, 32'd5);
    bus.CRST = 1'b1;
    tick();
    chk("abort_run_stat", {16'h0, bus.SEQ_STAT}, 32'h0);
    chk("abort_run_rst_en", {30'h0, bus.CORE_RST, bus.CORE_EN}, 32'h2);
    chk("abort_run_cnt", bus.CYCLE_CNT, 32'h0);
    bus.CRST = 1'b0;
    repeat (3) begin
      tick();
      chk("abort_no_restart", {16'h0, bus.SEQ_STAT}, 32'h0);
    end
    bus.CEXEC     = 1'b0;
    bus.CMEM_ADDR = 32'h0000_0444;
    tick();
    bus.CEXEC = 1'b1;
    tick();
    chk("abort_retrigger", {16'h0, bus.SEQ_STAT}, 32'h0009);
    chk("abort_retrig_pc", bus.CORE_PC, 32'h0000_0444);
    bus.CRST = 1'b1;
    tick();
    chk("abort_in_reset", {16'h0, bus.SEQ_STAT}, 32'h0);
    bus.CRST = 1'b0;

    // abort and start on the same edge
    bus.CEXEC = 1'b0;
    tick();
    bus.CEXEC = 1'b1;
    bus.CRST  = 1'b1;
    tick();
    chk("abort_vs_start", {16'h0, bus.SEQ_STAT}, 32'h0);
    bus.CRST = 1'b0;
    tick();
    chk("abort_vs_start_hold", {16'h0, bus.SEQ_STAT}, 32'h0);

    do_run(32'h0000_0500,  0, 16'h0001, 16'h0013, 32'd2,  1'b1, 1'b0);
    do_run(32'h0000_0600, 10, 16'h3301, 16'h3313, 32'd10, 1'b0, 1'b1);

    // asynchronous reset in the middle of a run
    bus.CEXEC = 1'b0;
    tick();
    bus.CMEM_ADDR = 32'h0000_0700;
    bus.CEXEC     = 1'b1;
    tick();
    repeat (RSTC + 2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stat", {16'h0, bus.SEQ_STAT}, 32'h0);
    chk("arst_pc", bus.CORE_PC, 32'h0);
    chk("arst_cnt", bus.CYCLE_CNT, 32'h0);
    chk("arst_rst_en", {30'h0, bus.CORE_RST, bus.CORE_EN}, 32'h2);
    bus.CEXEC = 1'b0;
    rst_n     = 1'b1;
    tick();
    chk("arst_after", {16'h0, bus.SEQ_STAT}, 32'h0);

    chk("sb_leftover", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
